// File: rtl/bht_predictor_if.sv
// Lookup/update bus of the branch history table.
// The master side is the pipeline (IF issues lookups, EX returns resolved
// branches); the slave side is the predictor.
interface bht_predictor_if #(
  parameter int unsigned IDX_W = 6,
  parameter int unsigned PC_W  = 32
);
  logic             pred_valid;
  logic [PC_W-1:0]  pred_pc;
  logic             pred_out_valid;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;

  modport master (
    output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken,
    input  pred_out_valid, pred_taken, pred_idx
  );

  modport slave (
    input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken,
    output pred_out_valid, pred_taken, pred_idx
  );
endinterface

// File: rtl/bht_predictor.sv
// Branch history table of ENTRIES saturating CTR_W-bit counters, indexed by
// word-aligned fetch-PC bits. Registered prediction one cycle after lookup;
// resolved-branch updates are written on the edge they are presented, with a
// write-to-read bypass for a same-cycle lookup of the same entry.
// Optional gshare indexing: define BHT_GSHARE_EN.
module bht_predictor #(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned GHR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  bht_predictor_if.slave    bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0 || CTR_W < 1 ||
      PC_W < IDX_W + 2 || GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_cfg
    $error("bht_predictor: illegal parameter combination");
  end

  typedef logic [CTR_W-1:0] ctr_t;
  typedef logic [IDX_W-1:0] idx_t;

  ctr_t ctr_q [ENTRIES];
  ctr_t ctr_d [ENTRIES];
  ctr_t upd_old;
  ctr_t upd_new;
  ctr_t look_ctr;
  idx_t look_idx;
  idx_t hist_idx;

  logic pred_out_valid_q, pred_out_valid_d;
  logic pred_taken_q, pred_taken_d;
  idx_t pred_idx_q, pred_idx_d;

`ifdef BHT_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Global history shifts in each resolved outcome; lookup sees the old value.
  always_comb begin
    ghr_d    = ghr_q;
    if (bus.upd_valid) begin
      ghr_d = GHR_W'({ghr_q, bus.upd_taken});
    end
    hist_idx = idx_t'(ghr_q);
  end

  // History register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else     ghr_q <= ghr_d;
  end
`else
  // Bimodal: no history contribution to the index.
  always_comb begin
    hist_idx = '0;
  end
`endif

  // Saturating counter update and next table contents.
  always_comb begin
    upd_old = ctr_q[bus.upd_idx];
    if (bus.upd_taken) begin
      upd_new = (upd_old == '1) ? upd_old : upd_old + ctr_t'(1);
    end else begin
      upd_new = (upd_old == '0) ? upd_old : upd_old - ctr_t'(1);
    end
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      ctr_d[i] = ctr_q[i];
    end
    if (bus.upd_valid) begin
      ctr_d[bus.upd_idx] = upd_new;
    end
  end

  // Lookup index and prediction, bypassing a same-cycle update to that entry.
  always_comb begin
    look_idx         = bus.pred_pc[IDX_W+1:2] ^ hist_idx;
    look_ctr         = (bus.upd_valid && (bus.upd_idx == look_idx)) ? upd_new
                                                                    : ctr_q[look_idx];
    pred_out_valid_d = bus.pred_valid;
    pred_taken_d     = look_ctr[CTR_W-1];
    pred_idx_d       = look_idx;
  end

  // Counter table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= ctr_d[i];
      end
    end
  end

  // Registered prediction outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_idx_q       <= '0;
    end else begin
      pred_out_valid_q <= pred_out_valid_d;
      pred_taken_q     <= pred_taken_d;
      pred_idx_q       <= pred_idx_d;
    end
  end

  assign bus.pred_out_valid = pred_out_valid_q;
  assign bus.pred_taken     = pred_taken_q;
  assign bus.pred_idx       = pred_idx_q;
endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor (64 entries, 2-bit counters, 32-bit PC).
module tb_bht_predictor;
  localparam int unsigned IDX_W = 6;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  bht_predictor_if #(.IDX_W(IDX_W), .PC_W(32)) bus ();

  bht_predictor #(
    .ENTRIES(64),
    .CTR_W  (2),
    .PC_W   (32),
    .GHR_W  (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             pv;
    logic [31:0]      pc;
    logic             uv;
    logic [IDX_W-1:0] ui;
    logic             ut;
    logic             ov;
    logic             tk;
    logic [IDX_W-1:0] ix;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [31:0] pc, input logic uv,
                       input logic [IDX_W-1:0] ui, input logic ut);
    bus.pred_valid = pv;
    bus.pred_pc    = pc;
    bus.upd_valid  = uv;
    bus.upd_idx    = ui;
    bus.upd_taken  = ut;
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic cycle(input string name, input logic pv, input logic [31:0] pc,
                       input logic uv, input logic [IDX_W-1:0] ui, input logic ut,
                       input logic ov, input logic tk, input logic [IDX_W-1:0] ix);
    drive(pv, pc, uv, ui, ut);
    @(posedge clk);
    #1;
    check({name, ".valid"}, 32'(bus.pred_out_valid), 32'(ov));
    check({name, ".taken"}, 32'(bus.pred_taken), 32'(tk));
    check({name, ".idx"}, 32'(bus.pred_idx), 32'(ix));
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, '0, 1'b0);
  endtask

  vec_t vt [20];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    @(posedge clk);
    #1;
    check("rst.valid", 32'(bus.pred_out_valid), 0);
    check("rst.taken", 32'(bus.pred_taken), 0);
    check("rst.idx", 32'(bus.pred_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifndef BHT_GSHARE_EN
    //        pv  pc            uv ui  ut   ov tk ix
    vt[0]  = '{1, 32'h0000_0040, 0, 0,  0,   1, 0, 16};
    vt[1]  = '{0, 32'h0000_0040, 1, 16, 1,   0, 0, 16};  // ctr16 -> 1
    vt[2]  = '{0, 32'h0000_0040, 1, 16, 1,   0, 1, 16};  // -> 2
    vt[3]  = '{0, 32'h0000_0040, 1, 16, 1,   0, 1, 16};  // -> 3
    vt[4]  = '{0, 32'h0000_0040, 1, 16, 1,   0, 1, 16};  // stays 3
    vt[5]  = '{1, 32'h0000_0040, 1, 16, 1,   1, 1, 16};  // 5th taken, 3
    vt[6]  = '{1, 32'h0000_0040, 1, 16, 0,   1, 1, 16};  // -> 2
    vt[7]  = '{1, 32'h0000_0040, 1, 16, 0,   1, 0, 16};  // -> 1
    vt[8]  = '{1, 32'h0000_0040, 1, 16, 0,   1, 0, 16};  // -> 0
    vt[9]  = '{1, 32'h0000_0040, 1, 16, 0,   1, 0, 16};  // stays 0
    vt[10] = '{1, 32'h0000_0040, 1, 16, 0,   1, 0, 16};  // stays 0
    vt[11] = '{1, 32'h0000_0040, 0, 0,  0,   1, 0, 16};
    vt[12] = '{1, 32'h0000_0040, 1, 16, 1,   1, 0, 16};  // 0 -> 1, no wrap
    vt[13] = '{0, 32'h0000_0014, 1, 5,  1,   0, 0, 5};   // ctr5 -> 1
    vt[14] = '{1, 32'h0000_0014, 1, 5,  1,   1, 1, 5};   // bypass -> 2
    vt[15] = '{1, 32'h0000_0040, 1, 5,  1,   1, 0, 16};  // ctr5 -> 3, read 16
    vt[16] = '{1, 32'h0000_0014, 1, 16, 1,   1, 1, 5};   // ctr16 -> 2, read 5
    vt[17] = '{1, 32'h0000_0040, 0, 0,  0,   1, 1, 16};
    vt[18] = '{1, 32'hFFFF_FFFC, 0, 0,  0,   1, 0, 63};
    vt[19] = '{1, 32'h1000_0017, 0, 0,  0,   1, 1, 5};   // high/low pc bits ignored

    for (int i = 0; i < 20; i++) begin
      cycle($sformatf("vec%0d", i), vt[i].pv, vt[i].pc, vt[i].uv, vt[i].ui, vt[i].ut,
            vt[i].ov, vt[i].tk, vt[i].ix);
    end

    // Train idx16 to 3, then pulse reset between edges.
    cycle("train", 1'b1, 32'h40, 1'b1, 6'd16, 1'b1, 1'b1, 1'b1, 6'd16);
    idle();
    #2 rst = 1'b1;
    #1;
    check("arst.valid", 32'(bus.pred_out_valid), 0);
    check("arst.taken", 32'(bus.pred_taken), 0);
    check("arst.idx", 32'(bus.pred_idx), 0);
    #1 rst = 1'b0;
    cycle("post_rst16", 1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b1, 1'b0, 6'd16);
    cycle("post_rst5", 1'b1, 32'h14, 1'b0, '0, 1'b0, 1'b1, 1'b0, 6'd5);

    // Updates presented while reset is held are lost.
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 6'd16, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle("rst_upd_lost", 1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b1, 1'b0, 6'd16);
`else
    // GHR: taken, taken -> 0b11; the third update's lookup uses 0b11 (16^3=19).
    cycle("gs_u1", 1'b0, 32'h40, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 6'd16);
    cycle("gs_u2", 1'b0, 32'h40, 1'b1, 6'd0, 1'b1, 1'b0, 1'b0, 6'd17);
    cycle("gs_u3", 1'b1, 32'h40, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 6'd19);
    cycle("gs_look", 1'b1, 32'h40, 1'b0, '0, 1'b0, 1'b1, 1'b0, 6'd22);
    cycle("gs_trn", 1'b1, 32'h40, 1'b1, 6'd22, 1'b1, 1'b1, 1'b0, 6'd22);
`endif

    idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
